// File: rtl/key_input_pkg.sv
// Shared definitions for the debounced key reader: state encoding,
// counter width and the board-clock timing defaults.
package key_input_pkg;

    // Width of the debounce and hold counters.
    localparam int CNT_W = 32;

    // Per-channel debounce FSM encoding.
    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    // Defaults for the 12 MHz board clock: 20 ms debounce, 1 s long press.
    localparam logic [CNT_W-1:0] DEF_DEB_CNT  = 32'd240000;
    localparam logic [CNT_W-1:0] DEF_LONG_CNT = 32'd12000000;

    // True while the accepted key state is "pressed", i.e. the states in
    // which the hold counter runs.
    function automatic logic is_held(input logic [1:0] st);
        return (st == ST_PRESSED) || (st == ST_RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/key_input_ch.sv
// One key channel: two-flop synchroniser, debounce FSM, hold counter and
// registered level / press / release / long-press outputs.
module key_input_ch
    import key_input_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEB_CNT  = DEF_DEB_CNT,
    parameter logic [CNT_W-1:0] LONG_CNT = DEF_LONG_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press
);

    localparam logic [CNT_W-1:0] DEB_LAST  = DEB_CNT - 1;
    localparam logic [CNT_W-1:0] LONG_LAST = LONG_CNT - 1;

    logic             sync1_q, sync2_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             s;

    assign s = ~sync2_q;

    // Next-state logic: debounce walk between the four states, hold counting.
    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        hcnt_d    = hcnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        if (is_held(state_q) && (hcnt_q != LONG_CNT)) begin
            hcnt_d = hcnt_q + 1'b1;
            long_d = (hcnt_q == LONG_LAST);
        end

        case (state_q)
            ST_RELEASED: begin
                if (s) begin
                    state_d = ST_PRESS_WAIT;
                    dcnt_d  = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!s) begin
                    state_d = ST_RELEASED;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d = ST_PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    hcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!s) begin
                    state_d = ST_RELEASE_WAIT;
                    dcnt_d  = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (s) begin
                    state_d = ST_PRESSED;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d   = ST_RELEASED;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_RELEASED;
            end
        endcase
    end

    // State, counters, synchroniser and output registers with async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= ST_RELEASED;
            dcnt_q    <= '0;
            hcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= key_n;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            hcnt_q    <= hcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;

endmodule

// File: rtl/key_input.sv
// Debounced reader for NKEY active-low push buttons; one independent
// channel per key, outputs concatenated bit-per-key.
module key_input
    import key_input_pkg::*;
#(
    parameter int               NKEY     = 3,
    parameter logic [CNT_W-1:0] DEB_CNT  = DEF_DEB_CNT,
    parameter logic [CNT_W-1:0] LONG_CNT = DEF_LONG_CNT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NKEY-1:0] key_n,
    output logic [NKEY-1:0] level,
    output logic [NKEY-1:0] press,
    output logic [NKEY-1:0] release_pulse,
    output logic [NKEY-1:0] long_press
);

    // One fully independent debounce channel per key pin.
    for (genvar i = 0; i < NKEY; i++) begin : g_ch
        key_input_ch #(
            .DEB_CNT  (DEB_CNT),
            .LONG_CNT (LONG_CNT)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .key_n         (key_n[i]),
            .level         (level[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i]),
            .long_press    (long_press[i])
        );
    end

endmodule

// File: tb/tb_key_input.sv
// Testbench for key_input: directed timing scenarios plus randomized key
// activity checked against a streak-counting behavioural model.
module tb_key_input;

    localparam int NKEY = 3;
    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NKEY-1:0] key_n = '1;
    logic [NKEY-1:0] level, press, rel_p, long_press;

    int passed = 0;
    int total  = 0;

    key_input #(
        .NKEY     (NKEY),
        .DEB_CNT  (32'(DEB)),
        .LONG_CNT (32'(LONG))
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_n         (key_n),
        .level         (level),
        .press         (press),
        .release_pulse (rel_p),
        .long_press    (long_press)
    );

    always #5 clk = ~clk;

    // Behavioural model: a level change is accepted once the synchronised
    // key disagrees with the accepted level for DEB+1 consecutive edges;
    // long press fires when LONG edges have elapsed with the key accepted.
    logic [NKEY-1:0] m_k1, m_k2, m_level, m_press, m_rel, m_long;
    int              m_streak [NKEY];
    int              m_hold   [NKEY];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k1    <= '1;
            m_k2    <= '1;
            m_level <= '0;
            m_press <= '0;
            m_rel   <= '0;
            m_long  <= '0;
            for (int c = 0; c < NKEY; c++) begin
                m_streak[c] <= 0;
                m_hold[c]   <= 0;
            end
        end else begin
            m_k1 <= key_n;
            m_k2 <= m_k1;
            for (int c = 0; c < NKEY; c++) begin
                automatic int   st     = ((!m_k2[c]) != m_level[c]) ? m_streak[c] + 1 : 0;
                automatic logic accept = (st == DEB + 1);
                m_press[c]  <= accept && !m_level[c];
                m_rel[c]    <= accept && m_level[c];
                m_level[c]  <= accept ? !m_level[c] : m_level[c];
                m_streak[c] <= accept ? 0 : st;
                if (accept && !m_level[c]) begin
                    m_hold[c] <= 0;
                    m_long[c] <= 1'b0;
                end else if (m_level[c]) begin
                    m_long[c] <= (m_hold[c] + 1 == LONG);
                    m_hold[c] <= (m_hold[c] < LONG) ? m_hold[c] + 1 : m_hold[c];
                end else begin
                    m_long[c] <= 1'b0;
                end
            end
        end
    end

    function automatic logic [4*NKEY-1:0] pack(input logic [NKEY-1:0] lv, input logic [NKEY-1:0] pr,
                                               input logic [NKEY-1:0] rl, input logic [NKEY-1:0] lp);
        return {lv, pr, rl, lp};
    endfunction

    // Outputs held at zero during reset and for 50 idle cycles after it.
    task automatic test_reset();
        for (int e = 0; e < 53; e++) begin
            if (e == 3) begin
                @(negedge clk);
                rst = 1'b0;
            end
            @(posedge clk); #1;
            total++;
            if (pack(level, press, rel_p, long_press) !== '0) begin
                $display("[TB] FAIL reset_idle cyc=%0d got=%h exp=0", e, pack(level, press, rel_p, long_press));
            end else passed++;
        end
    endtask

    // Single press on key 0: press/level timing, one long press, release.
    task automatic test_single_press();
        logic [4*NKEY-1:0] exp;
        @(negedge clk);
        key_n[0] = 1'b0;
        for (int e = 0; e < 56; e++) begin
            if (e == 40) begin
                @(negedge clk);
                key_n[0] = 1'b1;
            end
            @(posedge clk); #1;
            exp = pack(3'(e >= 6 && e < 46), 3'(e == 6), 3'(e == 46), 3'(e == 26));
            total++;
            if (pack(level, press, rel_p, long_press) !== exp) begin
                $display("[TB] FAIL single_press edge=%0d got=%h exp=%h", e, pack(level, press, rel_p, long_press), exp);
            end else passed++;
        end
    endtask

    // Key 1 bouncing with short low bursts never registers; then a real hold does.
    task automatic test_bounce();
        int npress = 0;
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                key_n[1] = (k < 3) ? 1'b0 : 1'b1;
                @(posedge clk); #1;
                total++;
                if (pack(level, press, rel_p, long_press) !== '0) begin
                    $display("[TB] FAIL bounce rep=%0d got=%h exp=0", r, pack(level, press, rel_p, long_press));
                end else passed++;
            end
        end
        @(negedge clk);
        key_n[1] = 1'b0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            npress += int'(press[1]);
        end
        total++;
        if (npress != 1 || level !== 3'b010) begin
            $display("[TB] FAIL bounce_hold presses=%0d level=%b exp presses=1 level=010", npress, level);
        end else passed++;
        @(negedge clk);
        key_n[1] = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        total++;
        if (level !== 3'b000) begin
            $display("[TB] FAIL bounce_release level=%b exp=000", level);
        end else passed++;
    endtask

    // Keys 0 and 2 together: pulses land in the same cycle.
    task automatic test_simultaneous();
        logic [4*NKEY-1:0] exp;
        @(negedge clk);
        key_n = 3'b010;
        for (int e = 0; e < 11; e++) begin
            @(posedge clk); #1;
            exp = pack((e >= 6) ? 3'b101 : 3'b000, (e == 6) ? 3'b101 : 3'b000, 3'b000, 3'b000);
            total++;
            if (pack(level, press, rel_p, long_press) !== exp) begin
                $display("[TB] FAIL simul_press edge=%0d got=%h exp=%h", e, pack(level, press, rel_p, long_press), exp);
            end else passed++;
        end
        @(negedge clk);
        key_n = 3'b111;
        for (int e = 0; e < 11; e++) begin
            @(posedge clk); #1;
            exp = pack((e < 6) ? 3'b101 : 3'b000, 3'b000, (e == 6) ? 3'b101 : 3'b000, 3'b000);
            total++;
            if (pack(level, press, rel_p, long_press) !== exp) begin
                $display("[TB] FAIL simul_release edge=%0d got=%h exp=%h", e, pack(level, press, rel_p, long_press), exp);
            end else passed++;
        end
    endtask

    // Async reset while key 0 is held: outputs clear at once, press re-detected.
    task automatic test_reset_mid();
        logic [4*NKEY-1:0] exp;
        @(negedge clk);
        key_n[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (level !== 3'b001) begin
            $display("[TB] FAIL mid_pre_level got=%b exp=001", level);
        end else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (pack(level, press, rel_p, long_press) !== '0) begin
            $display("[TB] FAIL mid_async_clear got=%h exp=0", pack(level, press, rel_p, long_press));
        end else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            exp = pack(3'(e >= 6), 3'(e == 6), 3'b000, 3'b000);
            total++;
            if (pack(level, press, rel_p, long_press) !== exp) begin
                $display("[TB] FAIL mid_repress edge=%0d got=%h exp=%h", e, pack(level, press, rel_p, long_press), exp);
            end else passed++;
        end
        @(negedge clk);
        key_n[0] = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    // Release accepted on the very edge the hold reaches LONG: both pulse.
    task automatic test_release_at_long();
        logic [4*NKEY-1:0] exp;
        @(negedge clk);
        key_n[2] = 1'b0;
        for (int e = 0; e < 32; e++) begin
            if (e == 20) begin
                @(negedge clk);
                key_n[2] = 1'b1;
            end
            @(posedge clk); #1;
            exp = pack({e >= 6 && e < 26, 2'b00}, {e == 6, 2'b00}, {e == 26, 2'b00}, {e == 26, 2'b00});
            total++;
            if (pack(level, press, rel_p, long_press) !== exp) begin
                $display("[TB] FAIL release_long edge=%0d got=%h exp=%h", e, pack(level, press, rel_p, long_press), exp);
            end else passed++;
        end
    endtask

    // Random per-key hold/bounce durations compared against the model every cycle.
    task automatic test_random();
        int remain [NKEY];
        for (int c = 0; c < NKEY; c++) remain[c] = $urandom_range(1, 8);
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            for (int c = 0; c < NKEY; c++) begin
                remain[c]--;
                if (remain[c] <= 0) begin
                    key_n[c] = ~key_n[c];
                    remain[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 9);
                end
            end
            @(posedge clk); #1;
            total++;
            if (pack(level, press, rel_p, long_press) !== pack(m_level, m_press, m_rel, m_long)) begin
                $display("[TB] FAIL random cyc=%0d got=%h exp=%h", n, pack(level, press, rel_p, long_press),
                         pack(m_level, m_press, m_rel, m_long));
            end else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_release_at_long();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
